screen_state_ctrl: RTL and testbench

//  Game-level screen sequencer for the Arkanoid top level. Tracks lives, ball-loss and level-clear

---
 rtl/screen_state_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_screen_state_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/screen_state_ctrl.sv
// Arkanoid screen sequencer: tracks lives, holds LOST/DEAD/WIN screens for a number of
// frames and drives the renderer selects. Define SCREEN_BLINK_EN to blink text in INIT/DEAD/WIN.
module screen_state_ctrl #(
  parameter int unsigned LIVES       = 3,
  parameter int unsigned HOLD_FRAMES = 120
`ifdef SCREEN_BLINK_EN
  ,
  parameter int unsigned BLINK_FRAMES = 30
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       start_btn,
  input  logic       ball_lost,
  input  logic       level_clear,
  output logic       init,
  output logic       dead,
  output logic       win,
  output logic       play,
  output logic       show_text,
  output logic [2:0] lives,
  output logic       new_game,
  output logic       respawn
);

  typedef enum logic [2:0] {
    ST_INIT,
    ST_PLAY,
    ST_LOST,
    ST_DEAD,
    ST_WIN
  } state_e;

  localparam logic [2:0] LIVES_INIT = 3'(LIVES);
  localparam logic [7:0] HOLD_CNT   = 8'(HOLD_FRAMES);

  state_e     state_q, state_d;
  logic [7:0] fcnt_q, fcnt_d;
  logic [2:0] lives_q, lives_d;
  logic       start_q;
  logic       start_rise;
  logic       entry;
  logic       init_q, init_d;
  logic       dead_q, dead_d;
  logic       win_q, win_d;
  logic       play_q, play_d;
  logic       new_game_q, new_game_d;
  logic       respawn_q, respawn_d;

  assign start_rise = start_btn & ~start_q;

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    lives_d    = lives_q;
    new_game_d = 1'b0;
    respawn_d  = 1'b0;

    case (state_q)
      ST_INIT: begin
        if (start_rise) begin
          state_d    = ST_PLAY;
          new_game_d = 1'b1;
          lives_d    = LIVES_INIT;
        end
      end
      ST_PLAY: begin
        // A simultaneous ball loss is forgiven when the level is cleared.
        if (level_clear) begin
          state_d = ST_WIN;
        end else if (ball_lost) begin
          if (lives_q != 3'd0) lives_d = lives_q - 3'd1;
          state_d = (lives_q > 3'd1) ? ST_LOST : ST_DEAD;
        end
      end
      ST_LOST: begin
        if (fcnt_q == HOLD_CNT) begin
          state_d   = ST_PLAY;
          respawn_d = 1'b1;
        end
      end
      ST_DEAD, ST_WIN: begin
        if (start_rise && (fcnt_q >= HOLD_CNT)) state_d = ST_INIT;
      end
      default: state_d = ST_INIT;
    endcase

    entry = (state_d != state_q);

    // Entry clears the count and swallows any tick in the same clock; 255 saturates.
    if (entry) begin
      fcnt_d = 8'd0;
    end else if (frame_tick && (fcnt_q != 8'hFF)) begin
      fcnt_d = fcnt_q + 8'd1;
    end else begin
      fcnt_d = fcnt_q;
    end

    init_d = (state_d == ST_INIT);
    dead_d = (state_d == ST_DEAD);
    win_d  = (state_d == ST_WIN);
    play_d = (state_d == ST_PLAY);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_INIT;
      fcnt_q     <= 8'd0;
      lives_q    <= LIVES_INIT;
      start_q    <= 1'b0;
      init_q     <= 1'b1;
      dead_q     <= 1'b0;
      win_q      <= 1'b0;
      play_q     <= 1'b0;
      new_game_q <= 1'b0;
      respawn_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      fcnt_q     <= fcnt_d;
      lives_q    <= lives_d;
      start_q    <= start_btn;
      init_q     <= init_d;
      dead_q     <= dead_d;
      win_q      <= win_d;
      play_q     <= play_d;
      new_game_q <= new_game_d;
      respawn_q  <= respawn_d;
    end
  end

`ifdef SCREEN_BLINK_EN
  localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);

  logic [7:0] bcnt_q, bcnt_d;
  logic       show_text_q, show_text_d;
  logic       blink_screen;

  always_comb begin
    bcnt_d       = bcnt_q;
    show_text_d  = show_text_q;
    blink_screen = (state_d == ST_INIT) || (state_d == ST_DEAD) || (state_d == ST_WIN);

    // Each blinking screen starts on its visible phase.
    if (!blink_screen || entry) begin
      bcnt_d      = 8'd0;
      show_text_d = 1'b1;
    end else if (frame_tick) begin
      if (bcnt_q == BLINK_LAST) begin
        bcnt_d      = 8'd0;
        show_text_d = ~show_text_q;
      end else begin
        bcnt_d = bcnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bcnt_q      <= 8'd0;
      show_text_q <= 1'b1;
    end else begin
      bcnt_q      <= bcnt_d;
      show_text_q <= show_text_d;
    end
  end

  assign show_text = show_text_q;
`else
  assign show_text = 1'b1;
`endif

  assign init     = init_q;
  assign dead     = dead_q;
  assign win      = win_q;
  assign play     = play_q;
  assign lives    = lives_q;
  assign new_game = new_game_q;
  assign respawn  = respawn_q;

endmodule

// File: tb/tb_screen_state_ctrl.sv
// Directed bench for screen_state_ctrl: a screen-level model checked every cycle plus
// hand-computed expectations at each scenario step.
module tb_screen_state_ctrl;

  localparam int LIVES = 3;
  localparam int HOLD  = 120;
`ifdef SCREEN_BLINK_EN
  localparam int BLINK = 2;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_tick = 1'b0;
  logic       start_btn = 1'b0;
  logic       ball_lost = 1'b0;
  logic       level_clear = 1'b0;
  logic       init, dead, win, play, show_text, new_game, respawn;
  logic [2:0] lives;

  int n_total = 0;
  int n_bad   = 0;
  bit chk_en  = 1'b0;

  screen_state_ctrl #(
    .LIVES       (LIVES),
    .HOLD_FRAMES (HOLD)
`ifdef SCREEN_BLINK_EN
    ,
    .BLINK_FRAMES(BLINK)
`endif
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .start_btn  (start_btn),
    .ball_lost  (ball_lost),
    .level_clear(level_clear),
    .init       (init),
    .dead       (dead),
    .win        (win),
    .play       (play),
    .show_text  (show_text),
    .lives      (lives),
    .new_game   (new_game),
    .respawn    (respawn)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Screen-level model: which screen is shown, lives left, frames seen on this screen.
  string m_screen     = "INIT";
  int    m_lives      = LIVES;
  int    m_frames     = 0;
  int    m_blink      = 0;
  bit    m_start_prev = 1'b0;
  bit    m_new_game   = 1'b0;
  bit    m_respawn    = 1'b0;

  always @(posedge clk) begin : model
    bit    rise;
    string nxt;
    rise       = start_btn && !m_start_prev;
    m_new_game = 1'b0;
    m_respawn  = 1'b0;
    if (rst) begin
      m_screen     = "INIT";
      m_lives      = LIVES;
      m_frames     = 0;
      m_blink      = 0;
      m_start_prev = 1'b0;
    end else begin
      nxt = m_screen;
      if (m_screen == "INIT" && rise) begin
        nxt        = "PLAY";
        m_new_game = 1'b1;
        m_lives    = LIVES;
      end else if (m_screen == "PLAY") begin
        if (level_clear) nxt = "WIN";
        else if (ball_lost) begin
          nxt     = (m_lives > 1) ? "LOST" : "DEAD";
          m_lives = m_lives - 1;
        end
      end else if (m_screen == "LOST" && m_frames == HOLD) begin
        nxt       = "PLAY";
        m_respawn = 1'b1;
      end else if ((m_screen == "DEAD" || m_screen == "WIN") && rise && m_frames >= HOLD) begin
        nxt = "INIT";
      end
      if (nxt != m_screen) begin
        m_frames = 0;
        m_blink  = 0;
      end else if (frame_tick) begin
        m_frames = (m_frames < 255) ? m_frames + 1 : 255;
        m_blink  = m_blink + 1;
      end
      m_screen     = nxt;
      m_start_prev = start_btn;
    end
  end

  always @(negedge clk) begin
    int exp_show;
    if (chk_en) begin
`ifdef SCREEN_BLINK_EN
      exp_show = (m_screen == "PLAY" || m_screen == "LOST") ? 1 : int'((m_blink / BLINK) % 2 == 0);
`else
      exp_show = 1;
`endif
      check("cyc_init",      init,       int'(m_screen == "INIT"));
      check("cyc_dead",      dead,       int'(m_screen == "DEAD"));
      check("cyc_win",       win,        int'(m_screen == "WIN"));
      check("cyc_play",      play,       int'(m_screen == "PLAY"));
      check("cyc_lives",     int'(lives), m_lives);
      check("cyc_new_game",  new_game,   m_new_game);
      check("cyc_respawn",   respawn,    m_respawn);
      check("cyc_show_text", show_text,  exp_show);
    end
  end

  // Inputs change 1 time unit after the edge and are sampled by the following edge.
  task automatic step(input logic ft, input logic bl, input logic lc, input logic sb);
    @(posedge clk);
    #1;
    frame_tick  = ft;
    ball_lost   = bl;
    level_clear = lc;
    start_btn   = sb;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic frames(input int n);
    repeat (n) step(1'b1, 1'b0, 1'b0, 1'b0);
    idle();
  endtask

  task automatic press();
    step(1'b0, 1'b0, 1'b0, 1'b1);
    idle();
  endtask

  task automatic lose();
    step(1'b0, 1'b1, 1'b0, 1'b0);
    idle();
  endtask

  initial begin
    idle();
    chk_en = 1'b1;
    idle();
    idle();
    check("rst_init", init, 1);
    check("rst_play", play, 0);
    check("rst_lives", int'(lives), 3);
    check("rst_show_text", show_text, 1);
    check("rst_new_game", new_game, 0);
    rst = 1'b0;
    idle();

`ifdef SCREEN_BLINK_EN
    begin
      int bl_exp[5] = '{1, 1, 0, 0, 1};
      check("blink_0", show_text, bl_exp[0]);
      for (int i = 1; i < 5; i++) begin
        step(1'b1, 1'b0, 1'b0, 1'b0);
        idle();
        check("blink_seq", show_text, bl_exp[i]);
      end
    end
`else
    frames(4);
    check("noblink_show_text", show_text, 1);
`endif

    // New game
    press();
    check("t1_new_game", new_game, 1);
    check("t1_play", play, 1);
    check("t1_init", init, 0);
    check("t1_lives", int'(lives), 3);
    idle();
    check("t1_new_game_1clk", new_game, 0);

    // Ball lost, hold, respawn
    lose();
    check("t2_lives", int'(lives), 2);
    check("t2_play", play, 0);
    frames(HOLD);
    check("t2_still_lost", play, 0);
    idle();
    check("t2_respawn", respawn, 1);
    check("t2_play_again", play, 1);
    idle();
    check("t2_respawn_1clk", respawn, 0);

    // Down to game over; the tick in the entry clock is not counted
    lose();
    frames(HOLD);
    idle();
    check("t3_lives_1", int'(lives), 1);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    idle();
    check("t3_dead", dead, 1);
    check("t3_lives_0", int'(lives), 0);
    frames(50);
    press();
    check("t3_early_start", dead, 1);
    frames(69);
    press();
    check("t3_start_at_119", dead, 1);
    frames(1);
    press();
    check("t3_start_at_120", init, 1);
    check("t3_lives_kept", int'(lives), 0);

    // Simultaneous level_clear and ball_lost; saturated frame count still releases WIN
    press();
    check("t4_lives_reload", int'(lives), 3);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    idle();
    check("t4_win", win, 1);
    check("t4_lives", int'(lives), 3);
    lose();
    check("t4_ignored_loss", int'(lives), 3);
    press();
    check("t4_early_start", win, 1);
    frames(300);
    press();
    check("t4_start_saturated", init, 1);

    // Reset while in LOST with one life left; start ignored during hold
    press();
    lose();
    frames(HOLD);
    idle();
    lose();
    check("t5_lives_1", int'(lives), 1);
    frames(10);
    press();
    check("t5_start_in_lost", play, 0);
    rst = 1'b1;
    idle();
    check("t5_init", init, 1);
    check("t5_lives", int'(lives), 3);
    check("t5_play", play, 0);
    rst = 1'b0;
    idle();
    idle();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
